// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the timer array.
// Channel registers sit in 16-byte windows; globals live above the select bit.
package timer_pkg;

    localparam int unsigned GLOBAL_SEL_BIT = 8;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_COMPARE = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    // Offsets inside the global region (addr[7:0] once the select bit is set)
    localparam logic [7:0] OFF_PRESCALE   = 8'h00;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h04;
    localparam logic [7:0] OFF_MTIME      = 8'h08;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_AUTO_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned STATUS_PEND_BIT = 0;

    typedef struct packed {
        logic ctrl;
        logic count;
        logic compare;
        logic status;
    } ch_wr_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: enable/reload/irq control, counter, compare and pending flag.
// Bus writes are applied after the tick update so software always wins.
module timer_channel
    import timer_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 tick,
    input  ch_wr_t               wr,
    input  logic [DataWidth-1:0] wdata,
    output logic                 en,
    output logic                 auto_reload,
    output logic                 irq_en,
    output logic [DataWidth-1:0] count,
    output logic [DataWidth-1:0] compare,
    output logic                 pending,
    output logic                 irq
);

    logic active;
    logic match;

    assign active = tick & en;
    assign match  = active & (count == compare);

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            count       <= '0;
            compare     <= '0;
            pending     <= 1'b0;
        end else begin
            if (match) begin
                pending <= 1'b1;
                if (auto_reload) count <= '0;
                else             en    <= 1'b0;
            end else if (active) begin
                count <= count + DataWidth'(1);
            end
            // a match in the same cycle keeps the flag set
            if (wr.status && wdata[STATUS_PEND_BIT] && !match) pending <= 1'b0;
            if (wr.ctrl) begin
                en          <= wdata[CTRL_EN_BIT];
                auto_reload <= wdata[CTRL_AUTO_BIT];
                irq_en      <= wdata[CTRL_IRQ_EN_BIT];
            end
            if (wr.count)   count   <= wdata;
            if (wr.compare) compare <= wdata;
        end
    end

    assign irq = pending & irq_en;

endmodule

// File: rtl/timer_array.sv
// Array of prescaled timer channels behind a simple register bus.
// Holds the global prescaler, MTIME, address decode and the registered read mux.
module timer_array
    import timer_pkg::*;
#(
    parameter int Channels      = 4,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    req_in,
    input  logic                    we_in,
    input  logic [AddressWidth-1:0] addr_in,
    input  logic [DataWidth-1:0]    wdata_in,
    output logic [DataWidth-1:0]    rdata_out,
    output logic [Channels-1:0]     irq_out,
    output logic                    irq_any_out
);

    logic [PrescaleWidth-1:0] prescale;
    logic [PrescaleWidth-1:0] psc_cnt;
    logic [DataWidth-1:0]     mtime;
    logic                     tick;

    logic [Channels-1:0]                en;
    logic [Channels-1:0]                auto_reload;
    logic [Channels-1:0]                irq_en;
    logic [Channels-1:0]                pending;
    logic [Channels-1:0][DataWidth-1:0] count;
    logic [Channels-1:0][DataWidth-1:0] compare;
    ch_wr_t [Channels-1:0]              ch_wr;

    logic [8:0]           addr_lo;
    logic                 is_global;
    logic [3:0]           ch_idx;
    logic [3:0]           ch_off;
    logic [7:0]           g_off;
    logic                 ch_hit;
    logic                 wr_req;
    logic                 rd_req;
    logic                 prescale_wr;
    logic [DataWidth-1:0] rd_mux;
    logic                 unused_addr;

    assign addr_lo     = addr_in[8:0];
    assign unused_addr = ^{addr_in[AddressWidth-1:9], addr_in[1:0]};
    assign is_global   = addr_lo[GLOBAL_SEL_BIT];
    assign ch_idx      = addr_lo[7:4];
    assign ch_off      = {addr_lo[3:2], 2'b00};
    assign g_off       = {addr_lo[7:2], 2'b00};
    assign ch_hit      = !is_global && ({1'b0, ch_idx} < 5'(Channels));
    assign wr_req      = req_in & we_in;
    assign rd_req      = req_in & ~we_in;
    assign prescale_wr = wr_req && is_global && (g_off == OFF_PRESCALE);

    assign tick = (psc_cnt == prescale);

    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < Channels; i++) begin
            if (wr_req && ch_hit && ch_idx == 4'(i)) begin
                case (ch_off)
                    OFF_CTRL:    ch_wr[i].ctrl    = 1'b1;
                    OFF_COUNT:   ch_wr[i].count   = 1'b1;
                    OFF_COMPARE: ch_wr[i].compare = 1'b1;
                    OFF_STATUS:  ch_wr[i].status  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_global) begin
            case (g_off)
                OFF_PRESCALE:   rd_mux = DataWidth'(prescale);
                OFF_IRQ_STATUS: rd_mux = DataWidth'(pending);
                OFF_MTIME:      rd_mux = mtime;
                default: ;
            endcase
        end else begin
            for (int i = 0; i < Channels; i++) begin
                if (ch_hit && ch_idx == 4'(i)) begin
                    case (ch_off)
                        OFF_CTRL: begin
                            rd_mux[CTRL_EN_BIT]     = en[i];
                            rd_mux[CTRL_AUTO_BIT]   = auto_reload[i];
                            rd_mux[CTRL_IRQ_EN_BIT] = irq_en[i];
                        end
                        OFF_COUNT:   rd_mux = count[i];
                        OFF_COMPARE: rd_mux = compare[i];
                        OFF_STATUS:  rd_mux[STATUS_PEND_BIT] = pending[i];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            prescale  <= '0;
            psc_cnt   <= '0;
            mtime     <= '0;
            rdata_out <= '0;
        end else begin
            if (tick) begin
                psc_cnt <= '0;
                mtime   <= mtime + DataWidth'(1);
            end else begin
                psc_cnt <= psc_cnt + PrescaleWidth'(1);
            end
            // restart the tick phase so the new rate applies from this edge
            if (prescale_wr) begin
                prescale <= wdata_in[PrescaleWidth-1:0];
                psc_cnt  <= '0;
            end
            if (rd_req) rdata_out <= rd_mux;
        end
    end

    for (genvar gi = 0; gi < Channels; gi++) begin : g_ch
        timer_channel #(
            .DataWidth(DataWidth)
        ) u_ch (
            .clk_in      (clk_in),
            .reset_in    (reset_in),
            .tick        (tick),
            .wr          (ch_wr[gi]),
            .wdata       (wdata_in),
            .en          (en[gi]),
            .auto_reload (auto_reload[gi]),
            .irq_en      (irq_en[gi]),
            .count       (count[gi]),
            .compare     (compare[gi]),
            .pending     (pending[gi]),
            .irq         (irq_out[gi])
        );
    end

    assign irq_any_out = |irq_out;

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: register table, directed timing sequences and a
// randomized run against a behavioural model of the register map.
module tb_timer_array;

    localparam int NCH = 4;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        req_in = 1'b0;
    logic        we_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic [31:0] rdata_out;
    logic [3:0]  irq_out;
    logic        irq_any_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    timer_array #(
        .Channels(4), .DataWidth(32), .AddressWidth(32), .PrescaleWidth(8)
    ) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .req_in      (req_in),
        .we_in       (we_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .rdata_out   (rdata_out),
        .irq_out     (irq_out),
        .irq_any_out (irq_any_out)
    );

    initial forever #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // All bus tasks start at a negedge and return at the negedge after their edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req_in = 1'b1; we_in = 1'b1; addr_in = a; wdata_in = d;
        @(negedge clk_in);
        req_in = 1'b0; we_in = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req_in = 1'b1; we_in = 1'b0; addr_in = a;
        @(negedge clk_in);
        req_in = 1'b0;
        d = rdata_out;
    endtask

    task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic do_reset();
        reset_in = 1'b0; req_in = 1'b0; we_in = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    task automatic wait_rise(input int ch, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            n++;
            if (irq_out[ch]) break;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en[NCH], m_auto[NCH], m_ie[NCH], m_pend[NCH];
    logic [31:0] m_cnt[NCH], m_cmp[NCH];
    logic [31:0] m_mtime, m_rdata;
    int          m_presc, m_since;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        int c;
        v = '0;
        if (a[8] == 1'b0) begin
            c = int'(a[7:4]);
            if (c < NCH) begin
                case (a[3:2])
                    2'd0: v = {29'd0, m_ie[c], m_auto[c], m_en[c]};
                    2'd1: v = m_cnt[c];
                    2'd2: v = m_cmp[c];
                    default: v = {31'd0, m_pend[c]};
                endcase
            end
        end else begin
            case (a[7:2])
                6'd0: v = 32'(m_presc);
                6'd1: for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
                6'd2: v = m_mtime;
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic logic [31:0] m_irq();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i] & m_ie[i];
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit tick;
        bit hit[NCH];
        int c;
        if (!reset_in) begin
            for (int i = 0; i < NCH; i++) begin
                m_en[i] = 0; m_auto[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
                m_cnt[i] = 0; m_cmp[i] = 0;
            end
            m_presc = 0; m_since = 0; m_mtime = 0; m_rdata = 0;
            return;
        end
        tick = (m_since % (m_presc + 1)) == m_presc;
        if (req_in && !we_in) m_rdata = m_read(addr_in);
        for (int i = 0; i < NCH; i++) begin
            hit[i] = 0;
            if (tick && m_en[i]) begin
                if (m_cnt[i] == m_cmp[i]) begin
                    hit[i] = 1;
                    m_pend[i] = 1;
                    if (m_auto[i]) m_cnt[i] = 0;
                    else           m_en[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        if (tick) m_mtime = m_mtime + 1;
        m_since++;
        if (req_in && we_in) begin
            if (!addr_in[8]) begin
                c = int'(addr_in[7:4]);
                if (c < NCH) begin
                    case (addr_in[3:2])
                        2'd0: begin
                            m_en[c] = wdata_in[0]; m_auto[c] = wdata_in[1]; m_ie[c] = wdata_in[2];
                        end
                        2'd1: m_cnt[c] = wdata_in;
                        2'd2: m_cmp[c] = wdata_in;
                        default: if (wdata_in[0] && !hit[c]) m_pend[c] = 0;
                    endcase
                end
            end else if (addr_in[7:2] == 6'd0) begin
                m_presc = int'(wdata_in[7:0]);
                m_since = 0;
            end
        end
    endtask

    typedef struct {
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] ra, input logic [31:0] e, input string nm);
        vec_t v;
        v.do_wr = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = e; v.nm = nm;
        vq.push_back(v);
    endtask

    initial begin
        int n, t0, t1, t2;
        logic [31:0] d, m1, m2, m3, prev;

        // ---------------- register table ----------------
        addv(0, 0, 0, 32'h000, 32'h0, "rst_ctrl0");
        addv(0, 0, 0, 32'h014, 32'h0, "rst_count1");
        addv(0, 0, 0, 32'h100, 32'h0, "rst_prescale");
        addv(0, 0, 0, 32'h104, 32'h0, "rst_irq_status");
        addv(1, 32'h008, 32'hDEADBEEF, 32'h008, 32'hDEADBEEF, "cmp0");
        addv(1, 32'h038, 32'h12345678, 32'h038, 32'h12345678, "cmp3");
        addv(1, 32'h024, 32'h0000A5A5, 32'h024, 32'h0000A5A5, "count2_hold");
        addv(1, 32'h010, 32'hFFFFFFFE, 32'h010, 32'h6, "ctrl1_mask");
        addv(1, 32'h01C, 32'hFFFFFFFF, 32'h01C, 32'h0, "w1c_idle");
        addv(1, 32'h104, 32'hF, 32'h104, 32'h0, "irq_status_ro");
        addv(1, 32'h10C, 32'hFFFF, 32'h10C, 32'h0, "unmapped");
        addv(1, 32'h058, 32'h77, 32'h058, 32'h0, "ch5_ignored");
        addv(1, 32'hFFFFFE08, 32'h55, 32'h008, 32'h55, "upper_addr_ignored");
        addv(1, 32'h100, 32'h1FF, 32'h100, 32'hFF, "prescale_width");
        addv(1, 32'h100, 32'h0, 32'h100, 32'h0, "prescale_zero");

        do_reset();
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_irq", 32'(irq_out), 32'h0);
        chk("rst_irq_any", 32'(irq_any_out), 32'h0);
        foreach (vq[i]) begin
            if (vq[i].do_wr) wr(vq[i].waddr, vq[i].wdata);
            rdchk(vq[i].nm, vq[i].raddr, vq[i].exp);
        end

        // ---------------- periodic mode ----------------
        do_reset();
        wr(32'h008, 3);
        wr(32'h000, 7);
        chk("per_irq_low", 32'(irq_out[0]), 32'h0);
        wait_rise(0, n);
        chk("per_first_rise", 32'(n), 32'd4);
        rdchk("per_count_reload", 32'h004, 32'h0);
        wr(32'h00C, 1);
        chk("per_w1c_clears", 32'(irq_out[0]), 32'h0);
        wait_rise(0, n);
        t1 = cyc;
        wr(32'h00C, 1);
        wait_rise(0, n);
        t2 = cyc;
        chk("per_period", 32'(t2 - t1), 32'd4);

        // ---------------- one-shot ----------------
        do_reset();
        wr(32'h018, 2);
        wr(32'h010, 5);
        repeat (6) @(negedge clk_in);
        rdchk("os_pending", 32'h01C, 32'h1);
        rdchk("os_en_cleared", 32'h010, 32'h4);
        rdchk("os_count_hold", 32'h014, 32'h2);
        chk("os_irq", 32'(irq_out), 32'h2);
        wr(32'h01C, 1);
        repeat (8) @(negedge clk_in);
        rdchk("os_no_repeat", 32'h01C, 32'h0);

        // ---------------- COUNT write vs tick, rdata hold, bad index ----------------
        do_reset();
        wr(32'h028, 32'hFFFF);
        wr(32'h020, 1);
        wr(32'h024, 32'h10);
        rdchk("count_wr_wins", 32'h024, 32'h10);
        prev = rdata_out;
        repeat (2) @(negedge clk_in);
        wr(32'h028, 32'h1234);
        chk("rdata_hold", rdata_out, prev);
        rdchk("ch5_read", 32'h054, 32'h0);

        // ---------------- W1C coincident with match ----------------
        do_reset();
        wr(32'h038, 1);
        wr(32'h030, 7);
        wait_rise(3, n);
        chk("w1c_first_rise", 32'(n), 32'd2);
        @(negedge clk_in);
        wr(32'h03C, 1);
        chk("w1c_match_irq", 32'(irq_out[3]), 32'h1);
        rdchk("w1c_match_pend", 32'h03C, 32'h1);
        chk("w1c_match_irq_any", 32'(irq_any_out), 32'h1);

        // ---------------- prescaler ----------------
        do_reset();
        wr(32'h008, 1);
        wr(32'h100, 3);
        t0 = cyc;
        wr(32'h000, 5);
        wait_rise(0, n);
        chk("psc_match_time", 32'(cyc - t0), 32'd8);
        rd(32'h108, m1);
        repeat (3) @(negedge clk_in);
        rd(32'h108, m2);
        repeat (3) @(negedge clk_in);
        rd(32'h108, m3);
        chk("psc_mtime_step1", m2 - m1, 32'h1);
        chk("psc_mtime_step2", m3 - m2, 32'h1);

        // ---------------- reset during counting ----------------
        do_reset();
        wr(32'h008, 2);
        wr(32'h000, 7);
        wait_rise(0, n);
        chk("rstmid_irq_any_pre", 32'(irq_any_out), 32'h1);
        reset_in = 1'b0; req_in = 1'b1; we_in = 1'b1; addr_in = 32'h010; wdata_in = 32'h7;
        @(negedge clk_in);
        chk("rstmid_irq_any", 32'(irq_any_out), 32'h0);
        chk("rstmid_irq", 32'(irq_out), 32'h0);
        chk("rstmid_rdata", rdata_out, 32'h0);
        reset_in = 1'b1; req_in = 1'b0; we_in = 1'b0;
        rdchk("rstmid_mtime", 32'h108, 32'h0);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++)
                rdchk($sformatf("rstmid_ch%0d_r%0d", c, r), 32'(c * 16 + r * 4), 32'h0);
        rdchk("rstmid_prescale", 32'h100, 32'h0);
        rdchk("rstmid_irq_status", 32'h104, 32'h0);

        // ---------------- randomized run against the model ----------------
        for (int it = 0; it < 3000; it++) begin
            int sel;
            logic [31:0] a, hi;
            reset_in = !(it == 0 || $urandom_range(0, 299) == 0);
            req_in = 1'($urandom_range(0, 1));
            we_in = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 32'($urandom_range(0, 5) * 16 + $urandom_range(0, 3) * 4);
            else if (sel == 8) a = 32'(32'h100 + $urandom_range(0, 3) * 4);
            else               a = 32'($urandom_range(0, 511));
            hi = $urandom();
            addr_in = {hi[31:9], a[8:0]};
            wdata_in = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 7)) : $urandom();
            model_step();
            @(negedge clk_in);
            chk("rnd_rdata", rdata_out, m_rdata);
            chk("rnd_irq", 32'(irq_out), m_irq());
            chk("rnd_irq_any", 32'(irq_any_out), 32'(m_irq() != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
